// File: rtl/relay_arb_pkg.sv
// Shared definitions for the relay latch arbiter: FSM encoding and parameter defaults.
package relay_arb_pkg;

  localparam int NREQ_DEF        = 4;
  localparam int WIDTH_DEF       = 8;
  localparam int HOLD_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first active request at or after ptr, wrapping.
module rr_picker #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  onehot,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  // Scan requesters starting from ptr; the first hit wins.
  always_comb begin
    int j;
    j      = 0;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!valid && req[j]) begin
        valid     = 1'b1;
        onehot[j] = 1'b1;
        idx       = PTR_W'(j);
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/relay_latch_arbiter.sv
// Arbitrates several requesters onto one shared relay D-flip-flop bank,
// with a one-cycle grant, abort on dropped request and a guard HOLD period.
module relay_latch_arbiter
  import relay_arb_pkg::*;
#(
  parameter int NREQ        = NREQ_DEF,
  parameter int WIDTH       = WIDTH_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      relay_q,
  output logic [WIDTH-1:0]      relay_qbar,
  output logic                  busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  arb_state_e       r_state;
  logic [NREQ-1:0]  r_gnt;
  logic             r_busy;
  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] r_winner;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [WIDTH-1:0] r_relay;

  logic [NREQ-1:0]  w_onehot;
  logic [PTR_W-1:0] w_idx;
  logic             w_valid;
  logic             w_wr_en;
  logic [PTR_W-1:0] w_ptr_next;
  logic [WIDTH-1:0] w_slice;

  rr_picker #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req    (req),
    .ptr    (r_rr_ptr),
    .onehot (w_onehot),
    .idx    (w_idx),
    .valid  (w_valid)
  );

  assign w_wr_en    = (r_state == GRANT) && req[r_winner];
  assign w_slice    = req_data[int'(r_winner)*WIDTH +: WIDTH];
  assign w_ptr_next = (r_winner == PTR_W'(NREQ - 1)) ? '0 : r_winner + PTR_W'(1);

  // Arbitration FSM with registered grant and busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_busy     <= 1'b0;
      r_rr_ptr   <= '0;
      r_winner   <= '0;
      r_hold_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_hold_cnt <= '0;
          if (w_valid) begin
            r_winner <= w_idx;
            r_gnt    <= w_onehot;
            r_busy   <= 1'b1;
            r_state  <= GRANT;
          end else begin
            r_gnt  <= '0;
            r_busy <= 1'b0;
          end
        end
        GRANT: begin
          r_gnt      <= '0;
          r_hold_cnt <= '0;
          if (req[r_winner]) begin
            r_rr_ptr <= w_ptr_next;
            if (HOLD_CYCLES == 0) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= HOLD;
              r_busy  <= 1'b1;
            end
          end else begin
            // Requester withdrew: no write, pointer untouched, skip the guard period.
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        HOLD: begin
          r_gnt <= '0;
          if (r_hold_cnt == HOLD_LAST) begin
            r_hold_cnt <= '0;
            r_state    <= IDLE;
            r_busy     <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
            r_busy     <= 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_gnt      <= '0;
          r_busy     <= 1'b0;
          r_hold_cnt <= '0;
        end
      endcase
    end
  end

  // Relay bank: plain enabled D flip-flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_relay <= '0;
    end else if (w_wr_en) begin
      r_relay <= w_slice;
    end else begin
      r_relay <= r_relay;
    end
  end

  assign gnt        = r_gnt;
  assign busy       = r_busy;
  assign relay_q    = r_relay;
  assign relay_qbar = ~r_relay;

endmodule

// File: tb/tb_relay_latch_arbiter.sv
// Directed self-checking bench for relay_latch_arbiter (default build and a HOLD_CYCLES=0 build).
module tb_relay_latch_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [7:0]  relay_q;
  logic [7:0]  relay_qbar;
  logic        busy;

  logic [3:0]  req0;
  logic [31:0] req_data0;
  logic [3:0]  gnt0;
  logic [7:0]  relay_q0;
  logic [7:0]  relay_qbar0;
  logic        busy0;

  int n_total;
  int n_bad;

  relay_latch_arbiter #(.NREQ(4), .WIDTH(8), .HOLD_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .relay_q    (relay_q),
    .relay_qbar (relay_qbar),
    .busy       (busy)
  );

  relay_latch_arbiter #(.NREQ(4), .WIDTH(8), .HOLD_CYCLES(0)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .req        (req0),
    .req_data   (req_data0),
    .gnt        (gnt0),
    .relay_q    (relay_q0),
    .relay_qbar (relay_qbar0),
    .busy       (busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input string tag);
    int cyc;
    cyc = 0;
    while (gnt == 4'b0000 && cyc < 10) begin
      tick();
      cyc++;
    end
    check_eq({tag, "_gnt_timeout"}, 32'(cyc < 10), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int cyc;
    cyc = 0;
    while (busy !== 1'b0 && cyc < 10) begin
      tick();
      cyc++;
    end
    check_eq({tag, "_idle_timeout"}, 32'(cyc < 10), 32'd1);
  endtask

  initial begin
    logic [3:0] exp_gnt;
    logic [7:0] exp_q;
    n_total   = 0;
    n_bad     = 0;
    rst       = 1'b1;
    req       = 4'b1111;
    req_data  = 32'h4433_2211;
    req0      = 4'b0000;
    req_data0 = 32'h0000_0000;

    // Reset with all requests active: requests must be ignored.
    tick();
    tick();
    check_eq("rst_gnt",   32'(gnt),        32'h0);
    check_eq("rst_q",     32'(relay_q),    32'h00);
    check_eq("rst_qbar",  32'(relay_qbar), 32'hFF);
    check_eq("rst_busy",  32'(busy),       32'h0);
    check_eq("rst_state", 32'(dut.r_state), 32'd0);

    // First edge with rst low arbitrates from pointer 0; then abort it.
    rst = 1'b0;
    tick();
    check_eq("resume_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    tick();
    check_eq("resume_abort_q",    32'(relay_q), 32'h00);
    check_eq("resume_abort_busy", 32'(busy),    32'h0);

    // Single request from requester 2.
    req_data = 32'h00A5_0000;
    req      = 4'b0100;
    tick();
    check_eq("single_gnt_n1",  32'(gnt),     32'h4);
    check_eq("single_busy_n1", 32'(busy),    32'h1);
    check_eq("single_q_n1",    32'(relay_q), 32'h00);
    tick();
    check_eq("single_q_n2",    32'(relay_q),    32'hA5);
    check_eq("single_qbar_n2", 32'(relay_qbar), 32'h5A);
    check_eq("single_gnt_n2",  32'(gnt),        32'h0);
    check_eq("single_busy_n2", 32'(busy),       32'h1);
    req = 4'b0000;
    tick();
    check_eq("single_busy_n3", 32'(busy), 32'h1);
    tick();
    check_eq("single_busy_n4", 32'(busy), 32'h0);
    check_eq("single_ptr",     32'(dut.r_rr_ptr), 32'd3);

    // Fairness: reset pointer, then all four continuously active.
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    req_data = 32'h4433_2211;
    req      = 4'b1111;
    for (int g = 0; g < 12; g++) begin
      exp_gnt = 4'b0001 << (g % 4);
      exp_q   = 8'(8'h11 * ((g % 4) + 1));
      wait_gnt("fair");
      check_eq($sformatf("fair_gnt%0d", g), 32'(gnt), 32'(exp_gnt));
      tick();
      check_eq($sformatf("fair_q%0d", g), 32'(relay_q), 32'(exp_q));
    end
    req = 4'b0000;
    wait_idle("fair");

    // Abort: prime pointer to 1 with a write from requester 0.
    req_data = 32'h0000_005B;
    req      = 4'b0001;
    tick();
    tick();
    req = 4'b0000;
    check_eq("prime_q", 32'(relay_q), 32'h5B);
    wait_idle("prime");
    check_eq("prime_ptr", 32'(dut.r_rr_ptr), 32'd1);
    req_data = 32'h0000_EE5B;
    req      = 4'b0010;
    tick();
    check_eq("abort_gnt", 32'(gnt), 32'h2);
    req = 4'b0001;
    tick();
    check_eq("abort_q",     32'(relay_q),       32'h5B);
    check_eq("abort_busy",  32'(busy),          32'h0);
    check_eq("abort_state", 32'(dut.r_state),   32'd0);
    check_eq("abort_ptr",   32'(dut.r_rr_ptr),  32'd1);
    tick();
    check_eq("abort_next_gnt", 32'(gnt), 32'h1);
    tick();
    req = 4'b0000;
    wait_idle("abort");

    // Reset in the first HOLD cycle after writing 3C.
    req_data = 32'h3C00_0000;
    req      = 4'b1000;
    tick();
    check_eq("hrst_gnt", 32'(gnt), 32'h8);
    tick();
    check_eq("hrst_q_pre",     32'(relay_q),     32'h3C);
    check_eq("hrst_state_pre", 32'(dut.r_state), 32'd2);
    rst = 1'b1;
    req = 4'b0000;
    tick();
    check_eq("hrst_q",     32'(relay_q),      32'h00);
    check_eq("hrst_qbar",  32'(relay_qbar),   32'hFF);
    check_eq("hrst_state", 32'(dut.r_state),  32'd0);
    check_eq("hrst_ptr",   32'(dut.r_rr_ptr), 32'd0);
    check_eq("hrst_busy",  32'(busy),         32'h0);
    rst = 1'b0;
    tick();

    // HOLD_CYCLES=0 build: back-to-back requests 0 and 1.
    req_data0 = 32'h0000_8877;
    req0      = 4'b0011;
    tick();
    check_eq("h0_gnt_n1",  32'(gnt0),  32'h1);
    check_eq("h0_busy_n1", 32'(busy0), 32'h1);
    tick();
    check_eq("h0_busy_n2", 32'(busy0),    32'h0);
    check_eq("h0_gnt_n2",  32'(gnt0),     32'h0);
    check_eq("h0_q_n2",    32'(relay_q0), 32'h77);
    tick();
    check_eq("h0_gnt_n3",  32'(gnt0), 32'h2);
    tick();
    req0 = 4'b0000;
    check_eq("h0_q_n4",    32'(relay_q0),    32'h88);
    check_eq("h0_qbar_n4", 32'(relay_qbar0), 32'h77);
    check_eq("h0_busy_n4", 32'(busy0),       32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
